// File: rtl/display_scan_ctrl_pkg.sv
// rtl/display_scan_ctrl_pkg.sv - shared constants for the countdown timer display scanner
package display_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  localparam logic [7:0] SEG_OFF      = 8'hFF;
  localparam logic [7:0] SEG_DOT_ONLY = 8'h7F;
  localparam logic [7:0] AN_ALL_OFF   = 8'hFF;

  // Active-low one-hot anode pattern for up to 8 digits; callers slice to width.
  function automatic logic [7:0] an_select(input int idx);
    logic [7:0] onehot;
    onehot = 8'h01 << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_hex_to_7seg.sv
// rtl/display_scan_ctrl_hex_to_7seg.sv - hex nibble to active-low 7-segment code {dp,g..a}
module hex_to_7seg (
  input  logic [3:0] in,
  input  logic       dp,
  output logic [7:0] q
);

  logic [6:0] segs;

  always_comb begin
    segs = 7'h7F;
    case (in)
      4'h0: segs = 7'h40;
      4'h1: segs = 7'h79;
      4'h2: segs = 7'h24;
      4'h3: segs = 7'h30;
      4'h4: segs = 7'h19;
      4'h5: segs = 7'h12;
      4'h6: segs = 7'h02;
      4'h7: segs = 7'h78;
      4'h8: segs = 7'h00;
      4'h9: segs = 7'h10;
      4'hA: segs = 7'h08;
      4'hB: segs = 7'h03;
      4'hC: segs = 7'h46;
      4'hD: segs = 7'h21;
      4'hE: segs = 7'h06;
      4'hF: segs = 7'h0E;
      default: segs = 7'h7F;
    endcase
  end

  assign q = {dp, segs};

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed 7-segment scan with dead-time and leading-zero blanking
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 100000,
  parameter int DEAD     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [4*N_DIGITS-1:0]         value,
  input  logic [N_DIGITS-1:0]           dp_mask,
  input  logic                          lz_blank,
  output logic [N_DIGITS-1:0]           an,
  output logic [7:0]                    seg,
  output logic [$clog2(N_DIGITS)-1:0]   digit_idx
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0]       CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]       DEAD_C   = CW'(DEAD);
  localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF   = AN_ALL_OFF[N_DIGITS-1:0];

  scan_state_t          state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [IW-1:0]        idx_nxt;
  logic                 latch;
  logic [N_DIGITS-1:0]  an_nxt;
  logic [7:0]           seg_nxt;
  logic [7:0]           an_full;
  logic [3:0]           lat_nib;
  logic                 lat_dot;
  logic                 lat_blank;
  logic [7:0]           conv_q;

  // Digit k is a leading zero when it and every more significant nibble are zero.
  function automatic logic lz_flag(input logic [4*N_DIGITS-1:0] v, input logic [IW-1:0] k);
    logic zero;
    zero = 1'b1;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (d >= int'(k) && v[4*d +: 4] != 4'h0) zero = 1'b0;
    end
    return zero && (k != '0);
  endfunction

  hex_to_7seg u_conv (
    .in (lat_nib),
    .dp (~lat_dot),
    .q  (conv_q)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = digit_idx;
    latch     = 1'b0;
    an_nxt    = AN_OFF;
    seg_nxt   = SEG_OFF;
    an_full   = an_select(int'(digit_idx));

    if (!en) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          latch     = 1'b1;
        end
        default: begin
          if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            idx_nxt = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            latch   = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
          state_nxt = (cnt_nxt < DEAD_C) ? ST_BLANK : ST_DRIVE;
        end
      endcase
    end

    // DRIVE is never entered on a slot-entry edge, so the latched digit is stable here.
    if (state_nxt == ST_DRIVE) begin
      if (lat_blank) begin
        if (lat_dot) begin
          an_nxt  = an_full[N_DIGITS-1:0];
          seg_nxt = SEG_DOT_ONLY;
        end
      end else begin
        an_nxt  = an_full[N_DIGITS-1:0];
        seg_nxt = conv_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      digit_idx <= '0;
      an        <= AN_OFF;
      seg       <= SEG_OFF;
      lat_nib   <= 4'h0;
      lat_dot   <= 1'b0;
      lat_blank <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      digit_idx <= idx_nxt;
      an        <= an_nxt;
      seg       <= seg_nxt;
      if (latch) begin
        lat_nib   <= value[4*idx_nxt +: 4];
        lat_dot   <= dp_mask[idx_nxt];
        lat_blank <= lz_blank & lz_flag(value, idx_nxt);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - randomized self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;

  localparam int N    = 4;
  localparam int DIV  = 8;
  localparam int DEAD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic        lz_blank = 1'b0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [1:0]  digit_idx;

  int n_cmp = 0;
  int n_bad = 0;

  display_scan_ctrl #(.N_DIGITS(N), .DIV(DIV), .DEAD(DEAD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .value     (value),
    .dp_mask   (dp_mask),
    .lz_blank  (lz_blank),
    .an        (an),
    .seg       (seg),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

  // Reference: time since enable determines digit and slot offset; digit data sampled at slot start.
  bit   m_active = 1'b0;
  int   m_t = 0;
  logic [3:0] m_nib = 4'h0;
  bit   m_dot = 1'b0;
  bit   m_blk = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int d;
    if (!rst_n || !en) begin
      m_active = 1'b0;
      m_t = 0;
    end else begin
      if (!m_active) begin
        m_active = 1'b1;
        m_t = 0;
      end else begin
        m_t = m_t + 1;
      end
      if (m_t % DIV == 0) begin
        d = (m_t / DIV) % N;
        m_nib = 4'((value >> (4 * d)) & 16'hF);
        m_dot = dp_mask[d];
        m_blk = lz_blank && (d != 0) && ((value >> (4 * d)) == 16'h0);
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic int m_digit();
    return m_active ? (m_t / DIV) % N : 0;
  endfunction

  function automatic bit m_lit();
    return m_active && (m_t % DIV >= DEAD);
  endfunction

  function automatic logic [13:0] expected();
    logic [3:0] e_an;
    logic [7:0] e_seg;
    e_an = 4'hF;
    e_seg = 8'hFF;
    if (m_lit()) begin
      if (!m_blk) begin
        e_an = ~(4'b0001 << m_digit());
        e_seg = {~m_dot, seg7(m_nib)};
      end else if (m_dot) begin
        e_an = ~(4'b0001 << m_digit());
        e_seg = 8'h7F;
      end
    end
    return {e_an, e_seg, 2'(m_digit())};
  endfunction

  task automatic restart();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
  endtask

  task automatic test_reset();
    bit found;
    @(negedge clk);
    n_cmp++;
    if ({an, seg, digit_idx} !== {4'hF, 8'hFF, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_hold: got an=%h seg=%h idx=%0d want an=f seg=ff idx=0", an, seg, digit_idx);
    end
    rst_n = 1'b1;
    en = 1'b1;
    value = 16'h1234;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (an !== 4'hF) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL reset_find_drive: got an=%h for 20 cycles want a lit digit", an);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({an, seg, digit_idx} !== {4'hF, 8'hFF, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_async: got an=%h seg=%h idx=%0d want an=f seg=ff idx=0", an, seg, digit_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, seg, digit_idx} !== expected()) begin
        n_bad++;
        $display("FAIL reset_release c%0d: got %h want %h", i, {an, seg, digit_idx}, expected());
      end
      if (i == 2 && an !== 4'b1110) begin
        n_bad++;
        $display("FAIL reset_first_lit: got an=%b want 1110", an);
      end
    end
  endtask

  task automatic test_pattern(input string name, input logic [15:0] v, input logic [3:0] dp,
                              input logic lz, input int cycles);
    value = v;
    dp_mask = dp;
    lz_blank = lz;
    restart();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, seg, digit_idx} !== expected()) begin
        n_bad++;
        $display("FAIL %s c%0d: got an=%b seg=%h idx=%0d want %h", name, i, an, seg, digit_idx, expected());
      end
    end
  endtask

  task automatic test_en_drop();
    bit found;
    int dark;
    value = 16'h1234;
    dp_mask = 4'h0;
    lz_blank = 1'b0;
    restart();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (digit_idx == 2'd2 && an == 4'b1011) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL en_drop_find: got no digit2 drive within 40 cycles want one");
    end
    en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({an, seg, digit_idx} !== {4'hF, 8'hFF, 2'd0}) begin
      n_bad++;
      $display("FAIL en_drop: got an=%h seg=%h idx=%0d want an=f seg=ff idx=0", an, seg, digit_idx);
    end
    en = 1'b1;
    dark = 0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (an === 4'hF) dark++;
      else found = 1'b1;
    end
    n_cmp++;
    if (dark != DEAD || an !== 4'b1110) begin
      n_bad++;
      $display("FAIL en_reenable: got dark=%0d an=%b want dark=%0d an=1110", dark, an, DEAD);
    end
  endtask

  task automatic test_midslot_change();
    bit found;
    value = 16'h1234;
    dp_mask = 4'h0;
    lz_blank = 1'b0;
    restart();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (m_digit() == 1 && m_t % DIV == 4) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL midslot_find: got no digit1 cnt4 within 40 cycles want one");
    end
    value = 16'h5678;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, seg, digit_idx} !== expected()) begin
        n_bad++;
        $display("FAIL midslot c%0d: got an=%b seg=%h idx=%0d want %h", i, an, seg, digit_idx, expected());
      end
      if (i < 3 && seg !== 8'hB0) begin
        n_bad++;
        $display("FAIL midslot_hold c%0d: got seg=%h want b0", i, seg);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, seg, digit_idx} !== expected() || $countones(~an) > 1) begin
        n_bad++;
        $display("FAIL random c%0d: got an=%b seg=%h idx=%0d want %h", i, an, seg, digit_idx, expected());
      end
      if ($urandom_range(39) == 0) en = ~en;
      if ($urandom_range(15) == 0) value = 16'($urandom_range(3) == 0 ? $urandom_range(255) : $urandom);
      if ($urandom_range(15) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(31) == 0) lz_blank = ~lz_blank;
    end
  endtask

  initial begin
    test_reset();
    test_pattern("scan_1234", 16'h1234, 4'h0, 1'b0, 70);
    test_pattern("lz_on_0005", 16'h0005, 4'h0, 1'b1, 40);
    test_pattern("lz_off_0005", 16'h0005, 4'h0, 1'b0, 40);
    test_pattern("dots_0000", 16'h0000, 4'b0100, 1'b1, 40);
    test_pattern("hex_abcd", 16'hABCD, 4'b1010, 1'b1, 40);
    test_en_drop();
    test_midslot_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
